// File: rtl/gp_cmd_pkg.sv
// gp_cmd_pkg: command field layout, opcode/state enums and decode for the GP-engine command fetch path.
package gp_cmd_pkg;
  localparam int OP_MSB     = 63;
  localparam int OP_LSB     = 62;
  localparam int DATA_MSB   = 61;
  localparam int DATA_LSB   = 32;
  localparam int ADDR_MSB   = 31;
  localparam int ADDR_LSB   = 0;
  localparam int CMD_STRIDE = 2;
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_END   = 2'b11
  } opcode_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DISPATCH,
    S_DONE
  } state_e;
  typedef struct packed {
    opcode_e     op;
    logic [29:0] data;
    logic [31:0] addr;
  } cmd_t;
  function automatic cmd_t decode_cmd(input logic [63:0] c);
    cmd_t d;
    d.op   = opcode_e'(c[OP_MSB:OP_LSB]);
    d.data = c[DATA_MSB:DATA_LSB];
    d.addr = c[ADDR_MSB:ADDR_LSB];
    return d;
  endfunction
endpackage

// File: rtl/cmd_fetch_unit.sv
// cmd_fetch_unit: reads 64-bit commands from the command buffer, decodes them and dispatches to the executor.
// Optional exe_ready stall timeout is enabled by defining CMD_FETCH_TIMEOUT_EN.
module cmd_fetch_unit
  import gp_cmd_pkg::*;
#(
  parameter int CMD_WIDTH        = 64,
  parameter int TRANS_ADDR_WIDTH = 8,
  parameter int CNT_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        start,
  input  logic [TRANS_ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]        cmd_num,
  input  logic                        abort,
  output logic                        cmd_rd_en,
  output logic [TRANS_ADDR_WIDTH-1:0] cmd_addr,
  input  logic                        cmd_rd_valid,
  input  logic [CMD_WIDTH-1:0]        cmd_out,
  output logic                        exe_valid,
  output logic [1:0]                  exe_op,
  output logic [31:0]                 exe_addr,
  output logic [29:0]                 exe_data,
  input  logic                        exe_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [CNT_WIDTH-1:0]        exec_cnt
);
  state_e                      r_state, w_next;
  logic [TRANS_ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]        r_cnt, r_num, w_cnt_inc;
  cmd_t                        r_cmd, w_dec;
  logic                        r_rd_en, r_exe_valid, r_done, r_err;
  logic                        w_start_ok, w_start_bad, w_cap, w_hs, w_last, w_to;
  assign w_dec       = decode_cmd(cmd_out);
  assign w_start_ok  = r_state == S_IDLE && start && !start_addr[0];
  assign w_start_bad = r_state == S_IDLE && start && start_addr[0];
  assign w_cap       = r_state == S_FETCH && r_rd_en && cmd_rd_valid;
  assign w_hs        = r_state == S_DISPATCH && r_exe_valid && exe_ready;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last      = (r_num == '0) ? (w_cnt_inc == CNT_WIDTH'(128)) : (w_cnt_inc == r_num);
`ifdef CMD_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to;
  logic            w_stall;
  assign w_stall = r_state == S_DISPATCH && r_exe_valid && !exe_ready;
  assign w_to    = w_stall && r_to == TO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_to <= '0;
    else r_to <= w_stall ? r_to + 1'b1 : '0;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES == 0;
  assign w_to             = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     w_next = w_start_ok ? S_FETCH : S_IDLE;
      S_FETCH:    if (w_cap) w_next = (w_dec.op == OP_END) ? S_DONE : (w_dec.op == OP_NOP) ? S_FETCH : S_DISPATCH;
      S_DISPATCH: w_next = w_hs ? (w_last ? S_DONE : S_FETCH) : (w_to ? S_DONE : S_DISPATCH);
      default:    w_next = S_IDLE;
    endcase
    if (abort && r_state inside {S_FETCH, S_DISPATCH}) w_next = S_DONE;
  end
  // read enable drops for one cycle after every capture so the buffer's
  // answer to the still-high request is never taken as the next command
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_exe_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_num       <= '0;
      r_cmd       <= '0;
    end else begin
      r_state     <= w_next;
      r_rd_en     <= w_next == S_FETCH && !w_cap;
      r_exe_valid <= w_next == S_DISPATCH;
      r_done      <= w_next == S_DONE || w_start_bad;
      if (w_start_bad || w_to) r_err <= 1'b1;
      else if (w_start_ok) r_err <= 1'b0;
      if (w_start_ok) begin
        r_addr <= start_addr;
        r_num  <= cmd_num;
        r_cnt  <= '0;
      end
      if (w_cap) r_cmd <= w_dec;
      if ((w_cap && w_dec.op == OP_NOP) || w_hs) r_addr <= r_addr + TRANS_ADDR_WIDTH'(CMD_STRIDE);
      if (w_hs) r_cnt <= w_cnt_inc;
    end
  assign cmd_rd_en = r_rd_en;
  assign cmd_addr  = r_addr;
  assign exe_valid = r_exe_valid;
  assign exe_op    = r_cmd.op;
  assign exe_addr  = r_cmd.addr;
  assign exe_data  = r_cmd.data;
  assign busy      = r_state == S_FETCH || r_state == S_DISPATCH;
  assign done      = r_done;
  assign err       = r_err;
  assign exec_cnt  = r_cnt;
endmodule

// File: tb/tb_cmd_fetch_unit.sv
// tb_cmd_fetch_unit: directed bench for cmd_fetch_unit with a command-buffer model and dispatch logger.
module tb_cmd_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [7:0]  cmd_num = '0;
  logic        abort = 1'b0;
  logic        cmd_rd_en;
  logic [7:0]  cmd_addr;
  logic        cmd_rd_valid = 1'b0;
  logic [63:0] cmd_out = '0;
  logic        exe_valid;
  logic [1:0]  exe_op;
  logic [31:0] exe_addr;
  logic [29:0] exe_data;
  logic        exe_ready = 1'b1;
  logic        busy, done, err;
  logic [7:0]  exec_cnt;
  logic        ahb_hold = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] mem [256];
  logic [63:0] disp_q[$];
  logic [7:0]  rd_q[$];
  int          done_cnt, rd_cycles, stall_cycles;
  int          tests = 0;
  int          fails = 0;

  cmd_fetch_unit #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .start(start), .start_addr(start_addr),
    .cmd_num(cmd_num), .abort(abort), .cmd_rd_en(cmd_rd_en), .cmd_addr(cmd_addr),
    .cmd_rd_valid(cmd_rd_valid), .cmd_out(cmd_out), .exe_valid(exe_valid),
    .exe_op(exe_op), .exe_addr(exe_addr), .exe_data(exe_data), .exe_ready(exe_ready),
    .busy(busy), .done(done), .err(err), .exec_cnt(exec_cnt)
  );

  always #5 clk = ~clk;

  // buffer answers one cycle after sampling cmd_rd_en, unless an AHB write holds it
  always @(posedge clk) begin
    cmd_rd_valid <= cmd_rd_en && !ahb_hold;
    if (cmd_rd_en && !ahb_hold) cmd_out <= mem[cmd_addr];
  end

  always @(posedge clk)
    if (clr) begin
      disp_q.delete();
      rd_q.delete();
      done_cnt = 0;
      rd_cycles = 0;
      stall_cycles = 0;
    end else begin
      if (exe_valid && exe_ready) disp_q.push_back({exe_op, exe_data, exe_addr});
      if (exe_valid && !exe_ready) stall_cycles++;
      if (done) done_cnt++;
      if (cmd_rd_en) begin
        rd_cycles++;
        if (rd_q.size() == 0 || rd_q[$] != cmd_addr) rd_q.push_back(cmd_addr);
      end
    end

  function automatic logic [63:0] mk(input logic [1:0] op, input logic [29:0] d, input logic [31:0] a);
    return {op, d, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] n);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    cmd_num = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk({tag, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {cmd_rd_en, exe_valid, busy, done, err}, 5'b0);
    chk("rst_exec_cnt", exec_cnt, 8'd0);
    chk("rst_cmd_addr", cmd_addr, 8'd0);
    chk("rst_exe_fields", {exe_op, exe_addr, exe_data}, 64'd0);

    clear_logs();
    pulse_start(8'h05, 8'd0);
    chk("odd_done", done, 1'b1);
    chk("odd_err", err, 1'b1);
    @(negedge clk);
    chk("odd_done_single", done, 1'b0);
    chk("odd_busy", busy, 1'b0);
    chk("odd_no_rd", rd_cycles, 0);

    mem[8'h00] = mk(2'b01, 30'h11, 32'h1000);
    mem[8'h02] = mk(2'b10, 30'h22, 32'h2000);
    mem[8'h04] = mk(2'b11, 30'h0, 32'h0);
    clear_logs();
    pulse_start(8'h00, 8'd0);
    chk("t1_err_cleared", err, 1'b0);
    wait_done("t1");
    chk("t1_exec_cnt", exec_cnt, 8'd2);
    @(negedge clk);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_disp_n", disp_q.size(), 2);
    chk("t1_disp0", disp_q[0], mk(2'b01, 30'h11, 32'h1000));
    chk("t1_disp1", disp_q[1], mk(2'b10, 30'h22, 32'h2000));
    chk("t1_rd_addrs", {rd_q[0], rd_q[1], rd_q[2]}, 24'h000204);
    chk("t1_idle", {busy, done, err}, 3'b0);

    mem[8'hFC] = mk(2'b01, 30'h1, 32'hA0);
    mem[8'hFE] = mk(2'b01, 30'h2, 32'hA4);
    mem[8'h00] = mk(2'b01, 30'h3, 32'hA8);
    clear_logs();
    pulse_start(8'hFC, 8'd3);
    wait_done("t2");
    chk("t2_exec_cnt", exec_cnt, 8'd3);
    chk("t2_cmd_addr_wrapped", cmd_addr, 8'h02);
    @(negedge clk);
    chk("t2_rd_n", rd_q.size(), 3);
    chk("t2_rd_addrs", {rd_q[0], rd_q[1], rd_q[2]}, 24'hFCFE00);
    chk("t2_disp2", disp_q[2], mk(2'b01, 30'h3, 32'hA8));
    chk("t2_done_pulses", done_cnt, 1);

    mem[8'h10] = mk(2'b00, 30'h3FF, 32'hFFFF);
    mem[8'h12] = mk(2'b01, 30'h3C, 32'h1234);
    clear_logs();
    pulse_start(8'h10, 8'd1);
    wait_done("t3");
    chk("t3_exec_cnt", exec_cnt, 8'd1);
    @(negedge clk);
    chk("t3_disp_n", disp_q.size(), 1);
    chk("t3_disp0", disp_q[0], mk(2'b01, 30'h3C, 32'h1234));
    chk("t3_rd_addrs", {rd_q[0], rd_q[1]}, 16'h1012);

    mem[8'h20] = mk(2'b10, 30'h155, 32'hABCD);
    clear_logs();
    ahb_hold = 1'b1;
    pulse_start(8'h20, 8'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rd_en_held", {cmd_rd_en, exe_valid}, 2'b10);
      @(negedge clk);
    end
    ahb_hold = 1'b0;
    wait_done("t4");
    chk("t4_exec_cnt", exec_cnt, 8'd1);
    @(negedge clk);
    chk("t4_disp_n", disp_q.size(), 1);
    chk("t4_disp0", disp_q[0], mk(2'b10, 30'h155, 32'hABCD));

    mem[8'h30] = mk(2'b01, 30'h7, 32'hDEAD);
    mem[8'h32] = mk(2'b11, 30'h0, 32'h0);
    clear_logs();
    exe_ready = 1'b0;
    pulse_start(8'h30, 8'd0);
    for (int i = 0; i < 20 && !exe_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("t5_stall_stable", {exe_valid, exe_op, exe_data, exe_addr}, {1'b1, mk(2'b01, 30'h7, 32'hDEAD)});
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_done", {done, exe_valid, cmd_rd_en, busy}, 4'b1000);
    chk("t5_exec_cnt", exec_cnt, 8'd0);
    chk("t5_err", err, 1'b0);
    @(negedge clk);
    chk("t5_done_single", done, 1'b0);
    chk("t5_no_disp", disp_q.size(), 0);
    exe_ready = 1'b1;

`ifdef CMD_FETCH_TIMEOUT_EN
    clear_logs();
    exe_ready = 1'b0;
    pulse_start(8'h30, 8'd0);
    wait_done("t6");
    chk("t6_err", err, 1'b1);
    chk("t6_exe_valid", exe_valid, 1'b0);
    @(negedge clk);
    chk("t6_stall_cycles", stall_cycles, 16);
    chk("t6_done_pulses", done_cnt, 1);
    exe_ready = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cmd_fetch_unit.md
Name: cmd_fetch_unit

Overview:
- Reader side of the GP-engine command buffer.
- Sequences through stored 64-bit commands: issues cmd_rd_en/cmd_addr, captures cmd_out on cmd_rd_valid, decodes each command, and dispatches it to the execution datapath over a valid/ready handshake.
- Sits between the command buffer and the GP-engine executor; started and monitored by the control-register block.

Parameters:
- CMD_WIDTH, 64, width of a fetched command.
- TRANS_ADDR_WIDTH, 8, command-buffer word address width.
- CNT_WIDTH, 8, width of command count and executed-command counter.
- TIMEOUT_CYCLES, 1024, exe_ready stall limit; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; sampled only in IDLE.
- start_addr  in  TRANS_ADDR_WIDTH  word address of the first command; must be even.
- cmd_num  in  CNT_WIDTH  commands to run; 0 = run until END opcode or 128 commands.
- abort  in  1  level; stops the sequence.
- cmd_rd_en  out  1  read request to the buffer (registered).
- cmd_addr  out  TRANS_ADDR_WIDTH  buffer word address (registered).
- cmd_rd_valid  in  1  buffer read data valid.
- cmd_out  in  CMD_WIDTH  command from the buffer.
- exe_valid  out  1  decoded command valid.
- exe_op  out  2  opcode: 00 NOP, 01 WRITE, 10 READ, 11 END.
- exe_addr  out  32  command target address, cmd[31:0].
- exe_data  out  30  command payload, cmd[61:32].
- exe_ready  in  1  executor accepts the command.
- busy  out  1  high in FETCH or DISPATCH.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error; cleared by the next accepted start.
- exec_cnt  out  CNT_WIDTH  commands dispatched in the current run.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal address and count registers 0.
- IDLE:
  - start with start_addr[0]=1 → err=1, done pulse next cycle, stay IDLE.
  - start with an even start_addr → clear err and exec_cnt, load the address, enter FETCH.
- FETCH:
  - cmd_rd_en=1, cmd_addr=current address.
  - The buffer answers one cycle after sampling cmd_rd_en, but may stall while an AHB write hits it; hold cmd_rd_en until cmd_rd_valid.
  - On cmd_rd_valid, capture cmd_out and drop cmd_rd_en next cycle.
- Stray cmd_rd_valid arriving outside FETCH is ignored.
- Capture and dispatch:
  - The decode takes opcode from cmd[63:62].
  - NOP: not dispatched and not counted; address += 2 (mod 256); back to FETCH.
  - END: not dispatched → DONE.
  - WRITE or READ: enter DISPATCH with exe_valid=1.
- DISPATCH:
  - exe_* stable while exe_valid && !exe_ready.
  - On exe_valid && exe_ready: exe_valid=0, exec_cnt+1, address += 2 with 8-bit wrap (0xFE → 0x00).
  - Then → DONE if exec_cnt reaches cmd_num (cmd_num≠0) or reaches 128 (cmd_num=0); else → FETCH.
- DONE: done=1 for one cycle, busy=0, → IDLE.
- abort (any non-IDLE state): exe_valid and cmd_rd_en drop next cycle → DONE. A handshake completing in that same cycle is counted. err is not set.
- start while not in IDLE is ignored.
- Reset mid-run: immediate return to IDLE with all outputs 0.
- Throughput: at most one command per 3 cycles.

Optional Feature:
- Macro: CMD_FETCH_TIMEOUT_EN.
- With the macro: a counter increments each cycle exe_valid && !exe_ready, clears on handshake. Reaching TIMEOUT_CYCLES → err=1, exe_valid=0, → DONE.
- Without the macro: DISPATCH waits indefinitely; no counter logic.

Decomposition:
- Package gp_cmd_pkg holds:
  - opcode enum (NOP/WRITE/READ/END);
  - field bit positions (OP_MSB=63, OP_LSB=62, DATA 61:32, ADDR 31:0);
  - FSM state enum (IDLE, FETCH, DISPATCH, DONE);
  - the command-stride constant 2.
- Single module. The decode is a package function; no sub-module is required.

Test Plan:
- Commands WRITE@0x00, READ@0x02, END@0x04; start_addr=0x00, cmd_num=0; exe_ready tied 1 → two dispatches (op 01 then 10), exec_cnt=2, done pulses, err=0.
- cmd_num=3, start_addr=0xFC, three WRITEs at 0xFC/0xFE/0x00 → cmd_addr sequence FC, FE, 00 with wrap; exec_cnt=3; done.
- NOP at 0x10, WRITE at 0x12, cmd_num=1 → NOP skipped and not counted; one dispatch of the 0x12 command.
- AHB write to the buffer held 4 cycles during FETCH → cmd_rd_en stays high; capture occurs only on cmd_rd_valid; correct command dispatched.
- exe_ready held low 10 cycles, then abort → exe_* stable during the stall; done one cycle after abort; exec_cnt=0; err=0.
- With CMD_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, exe_ready stuck 0 → err=1 after 16 stalled cycles; done pulse; odd start_addr=0x05 → err=1 and done without any cmd_rd_en.
